// File: rtl/fixed_to_fp8.sv
// rtl/fixed_to_fp8.sv - iterative signed fixed-point to fp8 {sign, exp[2:0], frac[3:0]} encoder
// Optional round-half-up on the guard bit: define FP8_ROUND_NEAREST_EN (default build truncates).
module fixed_to_fp8 #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 3,
  parameter int BIAS   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_ovf,
  output logic            out_unf
);

  // k counts left shifts; it never exceeds IN_W-1
  localparam int K_W   = $clog2(IN_W);
  // exponent of the leading one before any shift has happened
  localparam int E_TOP = IN_W - 1 - FRAC_W + BIAS;
  // guard bit sits five places below the leading one; absent for narrow inputs
  localparam int G_IDX = (IN_W >= 6) ? IN_W - 6 : 0;

  typedef enum logic [1:0] {IDLE, NORM, PACK, OUT} state_t;

  state_t            state;
  logic              sign;
  logic [IN_W-1:0]   mag;
  logic [K_W-1:0]    k;

  logic [IN_W-1:0]   abs_in;
  logic [3:0]        frac;
  logic signed [7:0] exp_s;
  logic [3:0]        frac_r;
  logic signed [7:0] exp_r;
  logic [7:0]        pack_data;
  logic              pack_ovf;
  logic              pack_unf;
`ifdef FP8_ROUND_NEAREST_EN
  logic              guard;
  logic [4:0]        frac_sum;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  // magnitude of the operand; the most negative input maps to 2^(IN_W-1) naturally
  always_comb begin
    abs_in = in_data[IN_W-1] ? -in_data : in_data;
  end

  // fraction bits just below the normalised leading one, and the unbiased-to-biased exponent
  always_comb begin
    frac  = 4'(mag >> (IN_W - 5));
    exp_s = 8'(E_TOP) - 8'(k);
  end

`ifdef FP8_ROUND_NEAREST_EN
  // round half up: a carry out of the fraction bumps the exponent
  always_comb begin
    guard    = (IN_W >= 6) ? mag[G_IDX] : 1'b0;
    frac_sum = {1'b0, frac} + {4'b0000, guard};
    frac_r   = frac_sum[3:0];
    exp_r    = exp_s + 8'(frac_sum[4]);
  end
`else
  // truncation: the bits below the fraction are simply dropped
  always_comb begin
    frac_r = frac;
    exp_r  = exp_s;
  end
`endif

  // classify the final exponent into zero / flush / saturate / normal word
  always_comb begin
    pack_data = {sign, exp_r[2:0], frac_r};
    pack_ovf  = 1'b0;
    pack_unf  = 1'b0;
    if (mag == '0) begin
      pack_data = 8'h00;
    end else if (exp_r < 0) begin
      pack_data = 8'h00;
      pack_unf  = 1'b1;
    end else if (exp_r > 8'sd7) begin
      pack_data = {sign, 7'h7F};
      pack_ovf  = 1'b1;
    end
  end

  // control FSM: accept, shift left until the MSB is set, pack, hold until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign     <= 1'b0;
      mag      <= '0;
      k        <= '0;
      out_data <= 8'h00;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign    <= in_data[IN_W-1];
            mag     <= abs_in;
            k       <= '0;
            out_ovf <= 1'b0;
            out_unf <= 1'b0;
            state   <= (in_data == '0) ? PACK : NORM;
          end
        end
        NORM: begin
          if (mag[IN_W-1]) begin
            state <= PACK;
          end else begin
            mag <= mag << 1;
            k   <= k + K_W'(1);
          end
        end
        PACK: begin
          out_data <= pack_data;
          out_ovf  <= pack_ovf;
          out_unf  <= pack_unf;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_fp8.sv
// tb/tb_fixed_to_fp8.sv - self-checking bench for fixed_to_fp8 (8-bit default and 16-bit wide instances)
module tb_fixed_to_fp8;

  logic clk;
  logic rst_n;

  logic [7:0]  a_in_data;
  logic        a_in_valid, a_in_ready;
  logic [7:0]  a_out_data;
  logic        a_out_valid, a_out_ready, a_out_ovf, a_out_unf;

  logic [15:0] b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_ready, b_out_ovf, b_out_unf;

  int checks = 0;
  int passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fixed_to_fp8 dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ovf(a_out_ovf), .out_unf(a_out_unf)
  );

  fixed_to_fp8 #(.IN_W(16), .FRAC_W(3), .BIAS(0)) dut_wide (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ovf(b_out_ovf), .out_unf(b_out_unf)
  );

  // reference: value = mag / 2^FRAC_W, leading one at p, fraction = next 4 bits of (mag/2^p - 1)
  function automatic void model(input int w, input int fw, input int bias, input logic [15:0] raw,
                                output logic [7:0] od, output logic ov, output logic un, output int lat);
    int v, mag, p, rem, frac, guard, e, s;
    v   = int'(raw) & ((1 << w) - 1);
    s   = (v >> (w - 1)) & 1;
    mag = (s != 0) ? (1 << w) - v : v;
    ov  = 1'b0;
    un  = 1'b0;
    if (mag == 0) begin
      od  = 8'h00;
      lat = 1;
      return;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    rem   = mag - (1 << p);
    frac  = (rem * 16) >> p;
    guard = ((rem * 32) >> p) & 1;
    e     = p - fw + bias;
    lat   = 2 + (w - 1 - p);
`ifdef FP8_ROUND_NEAREST_EN
    if (guard != 0) begin
      frac = frac + 1;
      if (frac == 16) begin
        frac = 0;
        e    = e + 1;
      end
    end
`else
    if (guard > 1) frac = 0;
`endif
    if (e < 0) begin
      od = 8'h00;
      un = 1'b1;
    end else if (e > 7) begin
      od = {s[0], 7'h7F};
      ov = 1'b1;
    end else begin
      od = {s[0], e[2:0], frac[3:0]};
    end
  endfunction

  // one full conversion with out_ready high; lat = edges from accept to first out_valid, -1 on timeout
  task automatic convert(input bit wide, input logic [15:0] d, output logic [7:0] od,
                         output logic ov, output logic un, output int lat);
    @(negedge clk);
    if (wide) begin
      b_in_data = d; b_in_valid = 1'b1; b_out_ready = 1'b1;
    end else begin
      a_in_data = d[7:0]; a_in_valid = 1'b1; a_out_ready = 1'b1;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = 0;
    while (!(wide ? b_out_valid : a_out_valid) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 64) lat = -1;
    od = wide ? b_out_data : a_out_data;
    ov = wide ? b_out_ovf  : a_out_ovf;
    un = wide ? b_out_unf  : a_out_unf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", a_in_ready); else passes++;
    checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else passes++;
    checks++; if (a_out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", a_out_data); else passes++;
    checks++; if ({a_out_ovf, a_out_unf} !== 2'b00) $display("FAIL reset_flags got %b want 00", {a_out_ovf, a_out_unf}); else passes++;
    checks++; if (b_in_ready !== 1'b1) $display("FAIL reset_wide_in_ready got %b want 1", b_in_ready); else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] din  [5] = '{8'h08, 8'hF4, 8'h80, 8'h00, 8'h7F};
`ifdef FP8_ROUND_NEAREST_EN
    logic [7:0] dexp [5] = '{8'h30, 8'hB8, 8'hF0, 8'h00, 8'h70};
`else
    logic [7:0] dexp [5] = '{8'h30, 8'hB8, 8'hF0, 8'h00, 8'h6F};
`endif
    int         dlat [5] = '{6, 6, 2, 1, 3};
    logic [7:0] od;
    logic       ov, un;
    int         lat;
    for (int i = 0; i < 5; i++) begin
      convert(1'b0, {8'h00, din[i]}, od, ov, un, lat);
      checks++; if (od !== dexp[i]) $display("FAIL directed_data in=%h got %h want %h", din[i], od, dexp[i]); else passes++;
      checks++; if (lat != dlat[i]) $display("FAIL directed_latency in=%h got %0d want %0d", din[i], lat, dlat[i]); else passes++;
      checks++; if ({ov, un} !== 2'b00) $display("FAIL directed_flags in=%h got %b want 00", din[i], {ov, un}); else passes++;
    end
  endtask

  task automatic test_zero_window();
    @(negedge clk);
    a_in_data = 8'h00; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    checks++; if ({a_in_ready, a_out_valid} !== 2'b00) $display("FAIL zero_pack_window got rdy/vld %b want 00", {a_in_ready, a_out_valid}); else passes++;
    @(posedge clk); #1;
    checks++; if ({a_in_ready, a_out_valid} !== 2'b01) $display("FAIL zero_out_window got rdy/vld %b want 01", {a_in_ready, a_out_valid}); else passes++;
    @(posedge clk); #1;
    checks++; if ({a_in_ready, a_out_valid} !== 2'b10) $display("FAIL zero_back_idle got rdy/vld %b want 10", {a_in_ready, a_out_valid}); else passes++;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit held_ok;
    @(negedge clk);
    a_in_data = 8'h08; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_data = 8'h10;
    cyc = 0;
    while (!a_out_valid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc >= 64) $display("FAIL bp_first_result timeout after %0d cycles want out_valid", cyc); else passes++;
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (a_out_data !== 8'h30 || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
        $display("FAIL bp_hold cycle=%0d got data=%h vld=%b rdy=%b want 30 1 0", i, a_out_data, a_out_valid, a_in_ready);
        held_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++; if (!held_ok) $display("FAIL bp_hold_summary got unstable want stable"); else passes++;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({a_in_ready, a_out_valid} !== 2'b10) $display("FAIL bp_release got rdy/vld %b want 10", {a_in_ready, a_out_valid}); else passes++;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_second_accept got in_ready %b want 0", a_in_ready); else passes++;
    cyc = 0;
    while (!a_out_valid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    checks++; if (a_out_data !== 8'h40 || cyc >= 64) $display("FAIL bp_second_data got %h want 40", a_out_data); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit stale;
    @(negedge clk);
    a_in_data = 8'h01; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL midreset_in_ready got %b want 1", a_in_ready); else passes++;
    checks++; if (a_out_valid !== 1'b0) $display("FAIL midreset_out_valid got %b want 0", a_out_valid); else passes++;
    checks++; if (a_out_data !== 8'h00) $display("FAIL midreset_out_data got %h want 00", a_out_data); else passes++;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) stale = 1'b1;
    end
    checks++; if (stale) $display("FAIL midreset_stale got out_valid 1 want 0"); else passes++;
  endtask

  task automatic test_wide_boundaries();
    logic [15:0] din  [9] = '{16'h7FFF, 16'h8000, 16'h0001, 16'h0004, 16'h0008, 16'hFFF8, 16'h0400, 16'h0800, 16'h0010};
    logic [7:0]  dexp [9] = '{8'h7F,    8'hFF,    8'h00,    8'h00,    8'h00,    8'h80,    8'h70,    8'h7F,    8'h10};
    logic [1:0]  dflg [9] = '{2'b10,    2'b10,    2'b01,    2'b01,    2'b00,    2'b00,    2'b00,    2'b10,    2'b00};
    logic [7:0]  od;
    logic        ov, un;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      convert(1'b1, din[i], od, ov, un, lat);
      checks++; if (od !== dexp[i]) $display("FAIL wide_data in=%h got %h want %h", din[i], od, dexp[i]); else passes++;
      checks++; if ({ov, un} !== dflg[i]) $display("FAIL wide_flags in=%h got %b want %b", din[i], {ov, un}, dflg[i]); else passes++;
    end
    convert(1'b1, 16'h0001, od, ov, un, lat);
    checks++; if (lat != 17) $display("FAIL wide_max_latency got %0d want 17", lat); else passes++;
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [7:0]  od, eod;
    logic        ov, un, eov, eun;
    int          lat, elat;
    for (int i = 0; i < 300; i++) begin
      bit wide;
      wide = (i % 2) == 1;
      if (wide) begin
        d = 16'($urandom >> $urandom_range(16, 31));
        if ($urandom_range(0, 1) == 1) d = -d;
        model(16, 3, 0, d, eod, eov, eun, elat);
      end else begin
        d = {8'h00, 8'($urandom_range(0, 255))};
        model(8, 3, 3, d, eod, eov, eun, elat);
      end
      convert(wide, d, od, ov, un, lat);
      checks++; if (od !== eod) $display("FAIL random_data w=%0d in=%h got %h want %h", wide ? 16 : 8, d, od, eod); else passes++;
      checks++; if ({ov, un} !== {eov, eun}) $display("FAIL random_flags w=%0d in=%h got %b want %b", wide ? 16 : 8, d, {ov, un}, {eov, eun}); else passes++;
      checks++; if (lat != elat) $display("FAIL random_latency w=%0d in=%h got %0d want %0d", wide ? 16 : 8, d, lat, elat); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_window();
    test_backpressure();
    test_reset_mid();
    test_wide_boundaries();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
